// File: rtl/rr_vc_arbiter.sv
// Round-robin switch-allocation arbiter with packet lock and optional flit budget.
// Grants are registered; a new owner can be granted on the same edge the old one releases.
module rr_vc_arbiter #(
  parameter int N        = 4,
  parameter int IDXW     = $clog2(N),
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    tail,
  input  logic            advance,
  output logic [N-1:0]    gnt,
  output logic            gnt_valid,
  output logic [IDXW-1:0] gnt_idx,
  output logic [N-1:0]    gnt_pulse,
  output logic            preempt,
  output logic [IDXW-1:0] ptr
);

  localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int HOLD_LAST_I = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0;
  localparam logic [HCW-1:0] HOLD_LAST = HOLD_LAST_I[HCW-1:0];
  localparam bit BUDGET_ON = (MAX_HOLD != 0);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  // First set bit of vec scanning cyclically from start; MSB of result is the found flag.
  function automatic logic [IDXW:0] rr_scan(input logic [N-1:0] vec, input logic [IDXW-1:0] start);
    logic [IDXW:0]   res;
    logic [IDXW-1:0] pos;
    int              sum;
    res = '0;
    for (int i = N - 1; i >= 0; i--) begin
      sum = int'(start) + i;
      if (sum >= N) begin
        sum = sum - N;
      end else begin
        sum = sum;
      end
      pos = IDXW'(sum);
      if (vec[pos]) begin
        res = {1'b1, pos};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [N-1:0] to_onehot(input logic [IDXW-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  state_t          state_r, state_s;
  logic [N-1:0]    gnt_r, gnt_s;
  logic            gnt_valid_r, gnt_valid_s;
  logic [IDXW-1:0] gnt_idx_r, gnt_idx_s;
  logic [N-1:0]    gnt_pulse_r, gnt_pulse_s;
  logic            preempt_r, preempt_s;
  logic [IDXW-1:0] ptr_r, ptr_s;
  logic [HCW-1:0]  hold_r, hold_s;

  logic [IDXW-1:0] next_ptr_s;
  logic [IDXW:0]   idle_scan_s;
  logic [IDXW:0]   rel_scan_s;
  logic            r1_s, r2_s, r3_s, release_s;

  // Release conditions and the two candidate scans (from ptr when idle, past the owner on release).
  always_comb begin
    next_ptr_s  = (gnt_idx_r == IDXW'(N - 1)) ? '0 : (gnt_idx_r + IDXW'(1));
    idle_scan_s = rr_scan(req, ptr_r);
    rel_scan_s  = rr_scan(req, next_ptr_s);
    r1_s        = advance && tail[gnt_idx_r];
    r2_s        = advance && BUDGET_ON && (hold_r == HOLD_LAST);
    r3_s        = !req[gnt_idx_r];
    release_s   = r1_s || r2_s || r3_s;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s     = state_r;
    gnt_s       = gnt_r;
    gnt_idx_s   = gnt_idx_r;
    gnt_pulse_s = '0;
    preempt_s   = 1'b0;
    ptr_s       = ptr_r;
    hold_s      = hold_r;
    case (state_r)
      ST_IDLE: begin
        if (idle_scan_s[IDXW]) begin
          state_s     = ST_BUSY;
          gnt_idx_s   = idle_scan_s[IDXW-1:0];
          gnt_s       = to_onehot(idle_scan_s[IDXW-1:0]);
          gnt_pulse_s = to_onehot(idle_scan_s[IDXW-1:0]);
          hold_s      = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (release_s) begin
          ptr_s     = next_ptr_s;
          hold_s    = '0;
          // Abandon ignores advance, so a budget hit only counts without R1 or R3.
          preempt_s = r2_s && !r1_s && !r3_s;
          if (rel_scan_s[IDXW]) begin
            state_s     = ST_BUSY;
            gnt_idx_s   = rel_scan_s[IDXW-1:0];
            gnt_s       = to_onehot(rel_scan_s[IDXW-1:0]);
            gnt_pulse_s = to_onehot(rel_scan_s[IDXW-1:0]);
          end else begin
            state_s   = ST_IDLE;
            gnt_idx_s = '0;
            gnt_s     = '0;
          end
        end else if (advance && BUDGET_ON && (hold_r != HOLD_LAST)) begin
          hold_s = hold_r + HCW'(1);
        end else begin
          hold_s = hold_r;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        gnt_s     = '0;
        gnt_idx_s = '0;
        ptr_s     = '0;
        hold_s    = '0;
      end
    endcase
    gnt_valid_s = |gnt_s;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      gnt_r       <= '0;
      gnt_valid_r <= 1'b0;
      gnt_idx_r   <= '0;
      gnt_pulse_r <= '0;
      preempt_r   <= 1'b0;
      ptr_r       <= '0;
      hold_r      <= '0;
    end else begin
      state_r     <= state_s;
      gnt_r       <= gnt_s;
      gnt_valid_r <= gnt_valid_s;
      gnt_idx_r   <= gnt_idx_s;
      gnt_pulse_r <= gnt_pulse_s;
      preempt_r   <= preempt_s;
      ptr_r       <= ptr_s;
      hold_r      <= hold_s;
    end
  end

  assign gnt       = gnt_r;
  assign gnt_valid = gnt_valid_r;
  assign gnt_idx   = gnt_idx_r;
  assign gnt_pulse = gnt_pulse_r;
  assign preempt   = preempt_r;
  assign ptr       = ptr_r;

endmodule

// File: tb/tb_rr_vc_arbiter.sv
// Directed self-checking bench: N=4 default budget (A), N=4 MAX_HOLD=4 (B), N=3 no budget (C).
module tb_rr_vc_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] tail;
  logic       advance;

  logic [3:0] a_gnt, a_pulse, b_gnt, b_pulse;
  logic [2:0] c_gnt, c_pulse;
  logic [1:0] a_idx, a_ptr, b_idx, b_ptr, c_idx, c_ptr;
  logic       a_valid, a_pre, b_valid, b_pre, c_valid, c_pre;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rr_vc_arbiter #(.N(4), .MAX_HOLD(16)) u_a (
    .clk(clk), .reset(reset), .req(req), .tail(tail), .advance(advance),
    .gnt(a_gnt), .gnt_valid(a_valid), .gnt_idx(a_idx), .gnt_pulse(a_pulse),
    .preempt(a_pre), .ptr(a_ptr)
  );

  rr_vc_arbiter #(.N(4), .MAX_HOLD(4)) u_b (
    .clk(clk), .reset(reset), .req(req), .tail(tail), .advance(advance),
    .gnt(b_gnt), .gnt_valid(b_valid), .gnt_idx(b_idx), .gnt_pulse(b_pulse),
    .preempt(b_pre), .ptr(b_ptr)
  );

  rr_vc_arbiter #(.N(3), .MAX_HOLD(0)) u_c (
    .clk(clk), .reset(reset), .req(req[2:0]), .tail(tail[2:0]), .advance(advance),
    .gnt(c_gnt), .gnt_valid(c_valid), .gnt_idx(c_idx), .gnt_pulse(c_pulse),
    .preempt(c_pre), .ptr(c_ptr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    req     = 4'b0000;
    tail    = 4'b0000;
    advance = 1'b0;
    step();
    reset = 1'b1;
  endtask

  logic [1:0] exp_a_seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [1:0] exp_c_seq [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};

  initial begin
    reset   = 1'b0;
    req     = 4'b0000;
    tail    = 4'b0000;
    advance = 1'b0;
    step();
    step();
    chk("rst_gnt",   32'(a_gnt),   32'h0);
    chk("rst_valid", 32'(a_valid), 32'h0);
    chk("rst_idx",   32'(a_idx),   32'h0);
    chk("rst_pulse", 32'(a_pulse), 32'h0);
    chk("rst_pre",   32'(a_pre),   32'h0);
    chk("rst_ptr",   32'(a_ptr),   32'h0);
    reset = 1'b1;

    // Single requester: grant, 3-flit packet, same-edge re-grant to itself.
    req = 4'b0010;
    step();
    chk("single_gnt",   32'(a_gnt),   32'h2);
    chk("single_pulse", 32'(a_pulse), 32'h2);
    chk("single_idx",   32'(a_idx),   32'h1);
    chk("single_valid", 32'(a_valid), 32'h1);
    advance = 1'b1;
    step();
    chk("single_hold_gnt",   32'(a_gnt),   32'h2);
    chk("single_hold_pulse", 32'(a_pulse), 32'h0);
    step();
    tail = 4'b0010;
    step();
    chk("single_regnt",       32'(a_gnt),   32'h2);
    chk("single_regnt_pulse", 32'(a_pulse), 32'h2);
    chk("single_regnt_ptr",   32'(a_ptr),   32'h2);
    advance = 1'b0;
    tail    = 4'b0000;
    req     = 4'b0000;
    step();
    chk("abandon_idle_gnt",   32'(a_gnt),   32'h0);
    chk("abandon_idle_valid", 32'(a_valid), 32'h0);
    chk("abandon_idle_ptr",   32'(a_ptr),   32'h2);

    // Full contention with 1-flit packets on N=4 (A) and N=3 (C).
    do_reset();
    req     = 4'b1111;
    tail    = 4'b1111;
    advance = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr4_idx",   32'(a_idx),   32'(exp_a_seq[i]));
      chk("rr4_pulse", 32'(a_pulse), 32'(4'b0001 << exp_a_seq[i]));
      chk("rr4_ptr",   32'(a_ptr),   32'(exp_a_seq[i]));
      chk("rr3_idx",   32'(c_idx),   32'(exp_c_seq[i]));
      chk("rr3_gnt",   32'(c_gnt),   32'(3'b001 << exp_c_seq[i]));
      chk("rr3_ptr",   32'(c_ptr),   32'(exp_c_seq[i]));
    end

    // Packet lock: owner 0, 4-flit packet, req[2] arrives mid-packet.
    do_reset();
    req = 4'b0001;
    step();
    chk("lock_gnt0", 32'(a_gnt), 32'h1);
    advance = 1'b1;
    step();
    req = 4'b0101;
    step();
    chk("lock_hold2", 32'(a_gnt), 32'h1);
    step();
    chk("lock_hold3", 32'(a_gnt), 32'h1);
    tail = 4'b0001;
    step();
    chk("lock_next_gnt",   32'(a_gnt),   32'h4);
    chk("lock_next_pulse", 32'(a_pulse), 32'h4);
    chk("lock_next_ptr",   32'(a_ptr),   32'h1);
    chk("tail_at_budget_pre", 32'(b_pre), 32'h0);
    chk("tail_at_budget_gnt", 32'(b_gnt), 32'h4);

    // Budget: owner 1, no tail, req[3] waiting, 4 advances on B.
    do_reset();
    req = 4'b0010;
    step();
    chk("bud_gnt1", 32'(b_gnt), 32'h2);
    req     = 4'b1010;
    advance = 1'b1;
    step();
    step();
    step();
    chk("bud_nopre3", 32'(b_pre), 32'h0);
    step();
    chk("bud_pre",      32'(b_pre),   32'h1);
    chk("bud_gnt3",     32'(b_gnt),   32'h8);
    chk("bud_pulse3",   32'(b_pulse), 32'h8);
    chk("bud_ptr",      32'(b_ptr),   32'h2);
    chk("nobud_a_gnt",  32'(a_gnt),   32'h2);
    chk("nobud_a_pre",  32'(a_pre),   32'h0);
    advance = 1'b0;
    step();
    chk("bud_pre_clr",   32'(b_pre),   32'h0);
    chk("bud_pulse_clr", 32'(b_pulse), 32'h0);
    chk("bud_gnt_keep",  32'(b_gnt),   32'h8);

    // Abandon: owner 2 drops req with advance high, next scan starts at 3.
    do_reset();
    req = 4'b0100;
    step();
    chk("ab_gnt2", 32'(a_gnt), 32'h4);
    req     = 4'b1001;
    advance = 1'b1;
    step();
    chk("ab_gnt3",  32'(a_gnt), 32'h8);
    chk("ab_ptr",   32'(a_ptr), 32'h3);
    chk("ab_nopre", 32'(a_pre), 32'h0);
    advance = 1'b0;

    // Asynchronous reset mid-packet clears outputs without a clock edge.
    #2;
    reset = 1'b0;
    #1;
    chk("async_gnt",   32'(a_gnt),   32'h0);
    chk("async_valid", 32'(a_valid), 32'h0);
    chk("async_idx",   32'(a_idx),   32'h0);
    chk("async_ptr",   32'(a_ptr),   32'h0);
    req = 4'b1000;
    #1;
    reset = 1'b1;
    step();
    chk("post_rst_gnt", 32'(a_gnt), 32'h8);
    chk("post_rst_idx", 32'(a_idx), 32'h3);
    chk("post_rst_ptr", 32'(a_ptr), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
